piso_shifter: RTL and testbench
===============================

// Module: piso_shifter
// PURPOSE
//  Parallel-in serial-out shift register; transmit side of the sipo serial link.
//  Accepts a WIDTH-bit word via valid/ready, then drives it one bit per clock on so.
//  Bit order is selectable per frame: mode 0 sends LSB first (matches sipo right-shift
//  reassembly), mode 1 sends MSB first (matches sipo left-shift reassembly).
// PARAMETERS
//  WIDTH       4   word length in bits (>=1)
//  IDLE_LEVEL  0   value driven on so when no frame is active
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-low (0 = reset)
//  load_valid  in   1      pdata/mode valid this cycle
//  load_ready  out  1      block can accept a word this cycle
//  pdata       in   WIDTH  parallel word to transmit
//  mode        in   1      0 = LSB first, 1 = MSB first; sampled with pdata
//  so          out  1      serial data out
//  so_valid    out  1      so carries a frame bit this cycle
//  busy        out  1      frame in progress
//  done        out  1      one-cycle pulse, coincident with the last bit of a frame
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, shreg=0, cnt=0, so=IDLE_LEVEL, so_valid=0,
//    done=0, busy=0; load_ready=1 immediately after rst deasserts.
//  - States: IDLE, SHIFT. load_ready = (state==IDLE), decoded from state register.
//  - IDLE: on edge with load_valid&&load_ready: latch mode into mode_q, state->SHIFT,
//    busy<=1, so<=first bit (pdata[0] if mode 0, pdata[WIDTH-1] if mode 1),
//    so_valid<=1, shreg<=remaining bits, cnt<=1. load_valid low -> hold, so=IDLE_LEVEL.
//  - Latency: first bit on so one cycle after the accepting edge.
//  - SHIFT, cnt<WIDTH: so<=next bit per mode_q, shreg shifts one place, cnt<=cnt+1.
//  - SHIFT, cnt==WIDTH: so<=IDLE_LEVEL, so_valid<=0, busy<=0, state->IDLE.
//  - so_valid high for exactly WIDTH consecutive cycles per frame.
//  - done<=1 on the edge that drives the final bit (cnt becomes WIDTH), else 0.
//    WIDTH=1: done asserted on the accepting edge.
//  - cnt width = $clog2(WIDTH+1); never exceeds WIDTH, no wrap.
//  - Back-to-back: load accepted in the first IDLE cycle; minimum one so_valid=0
//    cycle between frames.
//  - mode and pdata changes during SHIFT have no effect (latched at accept).
//  - load_valid during SHIFT is ignored (load_ready=0); upstream must hold.
//  - Reset mid-frame: frame abandoned, all outputs to reset values asynchronously.
// STRUCTURE
//  - Shared package piso_pkg: MODE_LSB_FIRST=1'b0, MODE_MSB_FIRST=1'b1,
//    state enum {IDLE, SHIFT}; sipo and bench import the same mode constants.
//  - Single module; no sub-module (shreg, cnt and 2-state FSM are small).
// TESTING (WIDTH=4, IDLE_LEVEL=0)
//  - Reset: rst=0 mid-SHIFT -> so=0, so_valid=0, busy=0, done=0 same cycle; ready=1.
//  - pdata=4'b1011, mode=0 accepted -> so = 1,1,0,1 on 4 cycles, done with 4th bit.
//  - pdata=4'b1011, mode=1 accepted -> so = 1,0,1,1; done with 4th bit; then ready=1.
//  - Hold load_valid=1 continuously with 4'hA then 4'h5 -> 4 bits, 1 idle cycle,
//    4 bits; second word accepted only when load_ready=1; no word lost or repeated.
//  - Toggle mode and pdata every cycle during SHIFT -> serial stream unchanged.
//  - Loopback into sipo (same mode, same rst) -> sipo po equals transmitted pdata.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the piso/sipo serial link: bit-order mode codes and
// the transmitter state encoding.
package piso_pkg;

    localparam logic MODE_LSB_FIRST = 1'b0;
    localparam logic MODE_MSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : piso_pkg

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word over valid/ready and
// drives it one bit per clock on so, LSB or MSB first as selected per frame.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pdata,
    input  logic             mode,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               so_q, so_d;
    logic               so_valid_q, so_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign load_ready = (state_q == IDLE);
    assign so         = so_q;
    assign so_valid   = so_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        so_d       = so_q;
        so_valid_d = so_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                so_d       = IDLE_LEVEL;
                so_valid_d = 1'b0;
                busy_d     = 1'b0;
                if (load_valid && load_ready) begin
                    state_d    = SHIFT;
                    mode_d     = mode;
                    busy_d     = 1'b1;
                    so_valid_d = 1'b1;
                    cnt_d      = CNT_ONE;
                    done_d     = (CNT_LAST == CNT_ONE);
                    if (mode == MODE_MSB_FIRST) begin
                        so_d    = pdata[WIDTH-1];
                        shreg_d = pdata << 1;
                    end else begin
                        so_d    = pdata[0];
                        shreg_d = pdata >> 1;
                    end
                end
            end

            SHIFT: begin
                if (cnt_q < CNT_LAST) begin
                    cnt_d  = cnt_q + CNT_ONE;
                    done_d = (cnt_d == CNT_LAST);
                    if (mode_q == MODE_MSB_FIRST) begin
                        so_d    = shreg_q[WIDTH-1];
                        shreg_d = shreg_q << 1;
                    end else begin
                        so_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    // Final bit has been on the line for a cycle; close the frame.
                    state_d    = IDLE;
                    so_d       = IDLE_LEVEL;
                    so_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            mode_q     <= MODE_LSB_FIRST;
            so_q       <= IDLE_LEVEL;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule : piso_shifter

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter (WIDTH=4, IDLE_LEVEL=0): reset, both bit
// orders, back-to-back loads, input changes mid-frame and sipo-style loopback.
module tb_piso_shifter;
    import piso_pkg::*;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pdata;
    logic             mode;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    piso_shifter #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .pdata      (pdata),
        .mode       (mode),
        .so         (so),
        .so_valid   (so_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for load_ready, then clocks the accepting edge.
    task automatic accept(input string name);
        int n = 0;
        while (load_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: load_ready=%b required 1 within 20 cycles", name, load_ready);
        end
        tick();
    endtask

    // Observes one frame starting at its first bit; ends in the idle cycle after it.
    task automatic run_frame(input string name, input logic [0:WIDTH-1] exp,
                             input bit toggle, output logic [0:WIDTH-1] got);
        for (int i = 0; i < WIDTH; i++) begin
            got[i] = so;
            checks++;
            if (so_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s bit%0d so_valid=%b required 1", name, i, so_valid);
            end
            checks++;
            if (so !== exp[i]) begin
                failures++;
                $display("FAIL %s bit%0d so=%b required %b", name, i, so, exp[i]);
            end
            checks++;
            if (done !== (i == WIDTH - 1)) begin
                failures++;
                $display("FAIL %s bit%0d done=%b required %b", name, i, done, (i == WIDTH - 1));
            end
            checks++;
            if (busy !== 1'b1 || load_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s bit%0d busy=%b load_ready=%b required busy=1 load_ready=0",
                         name, i, busy, load_ready);
            end
            if (toggle) begin
                mode  = ~mode;
                pdata = ~pdata;
                if (i == WIDTH - 1) load_valid = 1'b0;
            end
            tick();
        end
        checks++;
        if (so_valid !== 1'b0 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle: so_valid=%b so=%b busy=%b done=%b load_ready=%b required 0 0 0 0 1",
                     name, so_valid, so, busy, done, load_ready);
        end
    endtask

    task automatic send(input string name, input logic [WIDTH-1:0] word, input logic m,
                        input logic [0:WIDTH-1] exp, output logic [0:WIDTH-1] got);
        pdata      = word;
        mode       = m;
        load_valid = 1'b1;
        accept(name);
        load_valid = 1'b0;
        run_frame(name, exp, 1'b0, got);
    endtask

    task automatic test_reset();
        logic [0:WIDTH-1] got;
        rst        = 1'b0;
        load_valid = 1'b0;
        pdata      = '0;
        mode       = MODE_LSB_FIRST;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (so !== 1'b0 || so_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: so=%b so_valid=%b busy=%b done=%b required all 0",
                     so, so_valid, busy, done);
        end
        #3 rst = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: load_ready=%b required 1", load_ready);
        end

        // Mid-frame reset while the last bit (and done) is on the line.
        pdata      = 4'hF;
        mode       = MODE_LSB_FIRST;
        load_valid = 1'b1;
        accept("midreset");
        load_valid = 1'b0;
        repeat (WIDTH - 1) tick();
        checks++;
        if (done !== 1'b1 || so !== 1'b1 || so_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: done=%b so=%b so_valid=%b required 1 1 1", done, so, so_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (so !== 1'b0 || so_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async: so=%b so_valid=%b busy=%b done=%b load_ready=%b required 0 0 0 0 1",
                     so, so_valid, busy, done, load_ready);
        end
        tick();
        #3 rst = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1 || so_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release: load_ready=%b so_valid=%b required 1 0", load_ready, so_valid);
        end
        // A clean frame right after reset must be complete and unaffected.
        send("post_reset", 4'b1011, MODE_LSB_FIRST, 4'b1101, got);
    endtask

    task automatic test_lsb_first();
        logic [0:WIDTH-1] got;
        send("lsb_1011", 4'b1011, MODE_LSB_FIRST, 4'b1101, got);
        send("lsb_0001", 4'b0001, MODE_LSB_FIRST, 4'b1000, got);
    endtask

    task automatic test_msb_first();
        logic [0:WIDTH-1] got;
        send("msb_1011", 4'b1011, MODE_MSB_FIRST, 4'b1011, got);
        send("msb_0001", 4'b0001, MODE_MSB_FIRST, 4'b0001, got);
    endtask

    task automatic test_back_to_back();
        logic [0:WIDTH-1] got;
        pdata      = 4'hA;
        mode       = MODE_LSB_FIRST;
        load_valid = 1'b1;
        accept("b2b_first");
        pdata = 4'h5;
        run_frame("b2b_A", 4'b0101, 1'b0, got);
        tick();
        load_valid = 1'b0;
        run_frame("b2b_5", 4'b1010, 1'b0, got);
        tick();
        checks++;
        if (so_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_repeat: so_valid=%b busy=%b required 0 0", so_valid, busy);
        end
    endtask

    task automatic test_input_toggle();
        logic [0:WIDTH-1] got;
        pdata      = 4'b1011;
        mode       = MODE_MSB_FIRST;
        load_valid = 1'b1;
        accept("toggle");
        mode  = ~mode;
        pdata = ~pdata;
        run_frame("toggle", 4'b1011, 1'b1, got);
    endtask

    task automatic test_loopback();
        logic [0:WIDTH-1] got;
        logic [WIDTH-1:0] words [3] = '{4'h6, 4'hC, 4'h9};
        logic             modes [3] = '{MODE_LSB_FIRST, MODE_MSB_FIRST, MODE_MSB_FIRST};
        logic [0:WIDTH-1] exps  [3] = '{4'b0110, 4'b1100, 4'b1001};
        for (int k = 0; k < 3; k++) begin
            logic [WIDTH-1:0] sr = '0;
            send("loopback", words[k], modes[k], exps[k], got);
            for (int i = 0; i < WIDTH; i++) begin
                if (modes[k] == MODE_LSB_FIRST) sr = {got[i], sr[WIDTH-1:1]};
                else                            sr = {sr[WIDTH-2:0], got[i]};
            end
            checks++;
            if (sr !== words[k]) begin
                failures++;
                $display("FAIL loopback%0d: po=%h required %h", k, sr, words[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_input_toggle();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_shifter
